dmem_port_arbiter: RTL and testbench

//  Shares one variable-latency data-memory port between the CPU datapath (load/store via ALU address)
//  and a DMA/debug requester. Sequences each access through a req/ready/rvalid bus and stalls the

---
 rtl/dmem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares one variable-latency data-memory port between the CPU datapath and a
//   DMA/debug requester. One transaction is in flight at a time; each access is
//   sequenced IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE over a req/ready/rvalid bus.
//   The CPU is held off through cpu_stall until its own access completes.
//
// Ports
//   clk, reset                    clock (rising edge), asynchronous active-low reset
//   cpu_req/we/be/addr/wdata      CPU request, held stable until cpu_done
//   cpu_stall                     combinational cpu_req & ~cpu_done
//   cpu_done/err/rdata            completion pulse, timeout flag, held load data
//   dma_req/we/be/addr/wdata      DMA request, same rules as the CPU side
//   dma_gnt                       DMA currently owns the port (ISSUE/WAIT/DONE)
//   dma_done/err/rdata            as for the CPU side
//   mem_valid/we/be/addr/wdata    registered request towards memory
//   mem_ready                     memory accepts the request (honoured in ISSUE only)
//   mem_rvalid/mem_rdata          read return (honoured in WAIT only)
module dmem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DW/8-1:0]   cpu_be,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [DW-1:0]     cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DW/8-1:0]   dma_be,
  input  logic [AW-1:0]     dma_addr,
  input  logic [DW-1:0]     dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic              dma_err,
  output logic [DW-1:0]     dma_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  state_t        state, state_next;
  owner_t        owner, owner_next, last_owner;
  logic [CW-1:0] count;
  logic          timeout_hit;
  logic          finish;
  logic          finish_err;
  logic          capture;

  assign cpu_stall = cpu_req & ~cpu_done;

  always_comb begin
    state_next  = state;
    owner_next  = owner;
    finish      = 1'b0;
    finish_err  = 1'b0;
    capture     = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (count == TO_LAST);
    case (state)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          state_next = S_ISSUE;
          // Round-robin: on contention the side that was not served last wins.
          owner_next = (dma_req && (!cpu_req || last_owner == OWN_CPU)) ? OWN_DMA : OWN_CPU;
        end
      end
      S_ISSUE: begin
        // A write accepted in the final counted cycle still completes cleanly;
        // a read accepted then has no time left for its data and times out.
        if (mem_ready && mem_we) begin
          state_next = S_DONE;
          finish     = 1'b1;
        end else if (timeout_hit) begin
          state_next = S_DONE;
          finish     = 1'b1;
          finish_err = 1'b1;
        end else if (mem_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_next = S_DONE;
          finish     = 1'b1;
          capture    = 1'b1;
        end else if (timeout_hit) begin
          state_next = S_DONE;
          finish     = 1'b1;
          finish_err = 1'b1;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= OWN_CPU;
      last_owner <= OWN_DMA;
      count      <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dma_gnt    <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      dma_done   <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      mem_valid <= (state_next == S_ISSUE);
      dma_gnt   <= (state_next != S_IDLE) && (owner_next == OWN_DMA);
      cpu_done  <= finish && (owner == OWN_CPU);
      cpu_err   <= finish_err && (owner == OWN_CPU);
      dma_done  <= finish && (owner == OWN_DMA);
      dma_err   <= finish_err && (owner == OWN_DMA);

      if (state == S_IDLE && state_next == S_ISSUE) begin
        count <= '0;
        if (owner_next == OWN_DMA) begin
          mem_we    <= dma_we;
          mem_be    <= dma_be;
          mem_addr  <= dma_addr;
          mem_wdata <= dma_wdata;
        end else begin
          mem_we    <= cpu_we;
          mem_be    <= cpu_be;
          mem_addr  <= cpu_addr;
          mem_wdata <= cpu_wdata;
        end
      end else if (state == S_ISSUE || state == S_WAIT) begin
        count <= count + 1'b1;
      end

      if (capture) begin
        if (owner == OWN_DMA) dma_rdata <= mem_rdata;
        else                  cpu_rdata <= mem_rdata;
      end

      if (state == S_DONE) last_owner <= owner;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter. Each transaction's timeline (issue window, wait
// window, completion cycle, timeout) is computed arithmetically from the memory
// response delays the bench chooses; arbitration order is tracked with a single
// last-served flag.
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_stall, cpu_done, cpu_err;
  logic [BW-1:0] cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_gnt, dma_done, dma_err;
  logic [BW-1:0] dma_be;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_valid, mem_we, mem_ready, mem_rvalid;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_be(dma_be), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_done(dma_done),
    .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: who was served last (1 = DMA) and the held read data.
  bit            m_last;
  logic [DW-1:0] m_cpu_rdata, m_dma_rdata;

  task automatic drive_req(input bit own, input logic r, input logic we,
                           input logic [BW-1:0] be, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    if (own) begin
      dma_req = r; dma_we = we; dma_be = be; dma_addr = a; dma_wdata = d;
    end else begin
      cpu_req = r; cpu_we = we; cpu_be = be; cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic drive_junk(input bit own, input logic r);
    drive_req(own, r, 1'($urandom), BW'($urandom), AW'($urandom), DW'($urandom));
  endtask

  task automatic model_reset();
    m_last      = 1'b1;
    m_cpu_rdata = '0;
    m_dma_rdata = '0;
  endtask

  task automatic test_reset();
    logic [3*DW+AW+BW+7:0] got;
    reset = 1'b0;
    drive_junk(1'b0, 1'b0);
    drive_junk(1'b1, 1'b0);
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    got = {mem_valid, mem_we, mem_be, mem_addr, mem_wdata, cpu_done, cpu_err, cpu_rdata,
           dma_gnt, dma_done, dma_err, dma_rdata, cpu_stall};
    if (got !== '0) begin
      $display("FAIL reset_state got %h exp 0", got);
      miscompares++;
    end
    vectors++;
    #2 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // One transaction from an idle port. ready arrives rdy_dly cycles into ISSUE
  // (never when noresp); read data rv_dly cycles into WAIT.
  task automatic run_txn(input bit own, input logic we, input logic [BW-1:0] be,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int rdy_dly, input int rv_dly, input logic [DW-1:0] rd,
                         input bit noresp, input string tag);
    int ready_c, rv_c, done_c, last_issue;
    bit terr;
    logic [6:0] exp_v, got_v;
    ready_c = noresp ? 1000 : 1 + rdy_dly;
    rv_c    = ready_c + 1 + rv_dly;
    if (we) begin
      terr       = (ready_c > TO);
      done_c     = terr ? TO + 1 : ready_c + 1;
      last_issue = done_c - 1;
    end else begin
      terr       = !(ready_c < TO && rv_c <= TO);
      done_c     = terr ? TO + 1 : rv_c + 1;
      last_issue = (ready_c < TO) ? ready_c : TO;
    end
    for (int c = 0; c <= done_c + 1; c++) begin
      bit in_issue, in_wait, done_now;
      in_issue = (c >= 1 && c <= last_issue);
      in_wait  = (!we && c > last_issue && c < done_c);
      done_now = (c == done_c);
      if (c == 0) drive_req(own, 1'b1, we, be, addr, wdata);
      else        drive_junk(own, c <= done_c);
      drive_junk(!own, 1'b0);
      mem_ready  = in_issue ? (c == ready_c) : ($urandom_range(0, 2) == 0);
      mem_rvalid = in_wait ? (c == rv_c) : ($urandom_range(0, 2) == 0);
      mem_rdata  = (in_wait && c == rv_c) ? rd : DW'($urandom);
      @(negedge clk);
      if (done_now) begin
        if (!we && !terr) begin
          if (own) m_dma_rdata = rd; else m_cpu_rdata = rd;
        end
        m_last = own;
      end
      exp_v = {in_issue, !own && c < done_c, !own && done_now, !own && done_now && terr,
               own && c >= 1 && c <= done_c, own && done_now, own && done_now && terr};
      got_v = {mem_valid, cpu_stall, cpu_done, cpu_err, dma_gnt, dma_done, dma_err};
      if (got_v !== exp_v) begin
        $display("FAIL %s ctrl c=%0d got %b exp %b", tag, c, got_v, exp_v);
        miscompares++;
      end
      vectors++;
      if (in_issue) begin
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {we, be, addr, wdata}) begin
          $display("FAIL %s fields c=%0d got %h exp %h", tag, c,
                   {mem_we, mem_be, mem_addr, mem_wdata}, {we, be, addr, wdata});
          miscompares++;
        end
        vectors++;
      end
      if ({cpu_rdata, dma_rdata} !== {m_cpu_rdata, m_dma_rdata}) begin
        $display("FAIL %s rdata c=%0d got %h/%h exp %h/%h", tag, c,
                 cpu_rdata, dma_rdata, m_cpu_rdata, m_dma_rdata);
        miscompares++;
      end
      vectors++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    run_txn(1'b0, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 0, 0, '0, 1'b0, "store");
  endtask

  task automatic test_load();
    run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0100, '0, 0, 1, 32'hCAFE_F00D, 1'b0, "load");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 1'b1, 4'h3, 32'h0000_0200, 32'hAAAA_5555, 0, 0, '0, 1'b1, "to_issue");
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0300, '0, 0, 20, 32'hDEAD_BEEF, 1'b0, "to_wait");
    run_txn(1'b1, 1'b1, 4'hF, 32'h0000_0304, 32'h1, TO - 1, 0, '0, 1'b0, "wr_last");
    run_txn(1'b0, 1'b0, 4'hF, 32'h0000_0308, '0, TO - 1, 0, 32'h5A5A_5A5A, 1'b0, "rd_late");
  endtask

  // Both sides request writes together each round; the side not served last
  // goes first, the other follows once the winner drops its request.
  task automatic test_arbitration(input int rounds, input string tag);
    for (int r = 0; r < rounds; r++) begin
      bit first, second;
      logic [AW-1:0] a1, a2;
      int cpu_dc;
      first  = !m_last;
      second = !first;
      a1 = AW'($urandom);
      a2 = AW'($urandom);
      cpu_dc = first ? 5 : 2;
      for (int c = 0; c < 6; c++) begin
        logic [6:0] exp_v, got_v;
        bit dfirst, dsecond;
        drive_req(first, c <= 2, 1'b1, 4'hF, a1, 32'h0000_1111);
        drive_req(second, 1'b1, 1'b1, 4'hF, a2, 32'h0000_2222);
        mem_ready  = 1'b1;
        mem_rvalid = 1'($urandom);
        mem_rdata  = DW'($urandom);
        @(negedge clk);
        dfirst  = (c == 2);
        dsecond = (c == 5);
        exp_v = {c == 1 || c == 4, c < cpu_dc,
                 first ? dsecond : dfirst, 1'b0,
                 first ? (c == 1 || c == 2) : (c == 4 || c == 5),
                 first ? dfirst : dsecond, 1'b0};
        got_v = {mem_valid, cpu_stall, cpu_done, cpu_err, dma_gnt, dma_done, dma_err};
        if (got_v !== exp_v) begin
          $display("FAIL %s ctrl r=%0d c=%0d got %b exp %b", tag, r, c, got_v, exp_v);
          miscompares++;
        end
        vectors++;
        if (c == 1 || c == 4) begin
          if (mem_addr !== (c == 1 ? a1 : a2)) begin
            $display("FAIL %s addr r=%0d c=%0d got %h exp %h", tag, r, c, mem_addr,
                     (c == 1 ? a1 : a2));
            miscompares++;
          end
          vectors++;
        end
        @(posedge clk); #1;
      end
      m_last = second;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_txn(1'($urandom), 1'($urandom), BW'($urandom), AW'($urandom), DW'($urandom),
              int'($urandom_range(0, TO)), int'($urandom_range(0, TO)), DW'($urandom),
              ($urandom_range(0, 9) == 0), "rand");
    end
  endtask

  task automatic test_reset_in_wait();
    logic [2*DW+5:0] got;
    drive_req(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0500, '0);
    drive_junk(1'b0, 1'b0);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    if ({dma_gnt, mem_valid} !== 2'b10) begin
      $display("FAIL rst_wait_pre got %b exp 10", {dma_gnt, mem_valid});
      miscompares++;
    end
    vectors++;
    #2 reset = 1'b0;
    #1;
    got = {mem_valid, dma_gnt, cpu_done, dma_done, cpu_err, dma_err, cpu_rdata, dma_rdata};
    if (got !== '0) begin
      $display("FAIL rst_wait_async got %h exp 0", got);
      miscompares++;
    end
    vectors++;
    dma_req = 1'b0;
    model_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_arbitration(2, "arb_reset");
    test_timeout();
    test_random(40);
    test_arbitration(3, "arb_mid");
    test_reset_in_wait();
    test_arbitration(1, "arb_post");
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0600, '0, 1, 2, 32'h0BAD_CAFE, 1'b0, "post_rd");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
